lat_data_mem: RTL and testbench

Byte-addressed, little-endian data memory with a programmable fixed access latency. It sits directly downstream of the single-cycle MIPS core's load/store port. It consumes the core's read strobe, write strobe, address and write data, and returns read data plus a 3-bit status code the core uses to stall. It replaces the zero-latency memory model so the core's stall logic can be exercised under realistic multi-cycle access.

---
 rtl/lat_data_mem.sv | 121 ++++++++++++
 tb/tb_lat_data_mem.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lat_data_mem.sv
// Byte-addressed little-endian data memory with a fixed,
// programmable access latency and a registered status code.
module lat_data_mem #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    output logic [2:0]  state
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RBUSY = 3'd1,
        WBUSY = 3'd2,
        RDONE = 3'd3,
        WDONE = 3'd4,
        ERR   = 3'd5
    } state_t;

    logic [7:0] mem_array [0:DEPTH_BYTES-1];

    state_t       st_q, st_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [AW-3:0] widx_q, widx_d;
    logic [31:0]  wdat_q, wdat_d;
    logic         do_read, do_write;
    logic [AW-1:0] i0, i1, i2, i3;

    // Upper address bits only select an alias of the array.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW];

    // Byte lanes of the latched word; alignment keeps
    // all four inside the array without carry.
    assign i0 = {widx_q, 2'b00};
    assign i1 = {widx_q, 2'b01};
    assign i2 = {widx_q, 2'b10};
    assign i3 = {widx_q, 2'b11};

    assign state = st_q;

    // Next-state logic: sample requests only when not busy.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        wdat_d   = wdat_q;
        do_read  = 1'b0;
        do_write = 1'b0;
        unique case (st_q)
            IDLE, RDONE, WDONE, ERR: begin
                if (mem_read && mem_write) begin
                    st_d = ERR;
                end else if (mem_read || mem_write) begin
                    if (addr[1:0] != 2'b00) begin
                        st_d = ERR;
                    end else begin
                        widx_d = addr[AW-1:2];
                        wdat_d = wdata;
                        cnt_d  = CNT_INIT;
                        st_d   = mem_write ? WBUSY : RBUSY;
                    end
                end else begin
                    st_d = IDLE;
                end
            end
            RBUSY, WBUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (st_q == WBUSY) begin
                    do_write = 1'b1;
                    st_d     = WDONE;
                end else begin
                    do_read = 1'b1;
                    st_d    = RDONE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Control state, request latch and read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= IDLE;
            cnt_q  <= 4'd0;
            widx_q <= '0;
            wdat_q <= 32'd0;
            rdata  <= 32'd0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            widx_q <= widx_d;
            wdat_q <= wdat_d;
            if (do_read) begin
                rdata <= {mem_array[i3], mem_array[i2],
                          mem_array[i1], mem_array[i0]};
            end
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_array[i0] <= wdat_q[7:0];
            mem_array[i1] <= wdat_q[15:8];
            mem_array[i2] <= wdat_q[23:16];
            mem_array[i3] <= wdat_q[31:24];
        end
    end

endmodule

// File: tb/tb_lat_data_mem.sv
// Self-checking bench for lat_data_mem: table-driven
// transactions, scoreboard of completions, corner sequences.
module tb_lat_data_mem;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] wdata, addr, rdata;
    logic [2:0]  state;

    logic        rd1, wr1;
    logic [31:0] d1, a1, rdata1;
    logic [2:0]  state1;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'd0;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] rd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        int          busy;
        logic [2:0]  done;
        int          idle;
    } vec_t;

    lat_data_mem #(.DEPTH_BYTES(1024), .LATENCY(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .wdata(wdata), .addr(addr),
        .rdata(rdata), .state(state)
    );

    lat_data_mem #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_read(rd1), .mem_write(wr1),
        .wdata(d1), .addr(a1),
        .rdata(rdata1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    // Scoreboard: every DONE/ERR cycle consumes one entry.
    always @(negedge clk) begin
        if (rst && (state == 3'd3 || state == 3'd4 ||
                    state == 3'd5)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got state %0d expected none",
                         state);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_code", {29'd0, state}, {29'd0, e.code});
                chk("sb_rdata", rdata, e.rd);
            end
        end
    end

    // Called at a negedge with the DUT in an accepting state.
    task automatic txn(input vec_t v);
        exp_t e;
        logic [2:0] bcode;
        bcode = v.rd ? 3'd1 : 3'd2;
        e.code = v.done;
        e.rd = (v.done == 3'd3) ? v.exp : last_rd;
        sbq.push_back(e);
        mem_read = v.rd;
        mem_write = v.wr;
        addr = v.a;
        wdata = v.d;
        @(posedge clk); #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = $urandom;
        wdata = $urandom;
        for (int k = 0; k < v.busy; k++) begin
            chk("busy_state", {29'd0, state}, {29'd0, bcode});
            @(posedge clk); #1;
        end
        chk("done_state", {29'd0, state}, {29'd0, v.done});
        if (v.done == 3'd3) last_rd = v.exp;
        @(negedge clk);
        for (int k = 0; k < v.idle; k++) begin
            @(posedge clk); #1;
            chk("idle_state", {29'd0, state}, 32'd0);
            chk("idle_rdata", rdata, last_rd);
            @(negedge clk);
        end
    endtask

    vec_t tbl[11];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 1, 32'h10, 32'h12345678, 0, 3, 3'd4, 0};
        tbl[1]  = '{1, 0, 32'h10, 0, 32'h12345678, 3, 3'd3, 1};
        tbl[2]  = '{0, 1, 32'h30, 32'h0, 0, 3, 3'd4, 0};
        tbl[3]  = '{0, 1, 32'h20, 32'hDEADBEEF, 0, 3, 3'd4, 0};
        tbl[4]  = '{1, 0, 32'h20, 0, 32'hDEADBEEF, 3, 3'd3, 1};
        tbl[5]  = '{1, 0, 32'h22, 0, 0, 0, 3'd5, 1};
        tbl[6]  = '{1, 1, 32'h20, 32'h55555555, 0, 0, 3'd5, 1};
        tbl[7]  = '{0, 1, 32'h404, 32'hA5A5A5A5, 0, 3, 3'd4, 0};
        tbl[8]  = '{1, 0, 32'h4, 0, 32'hA5A5A5A5, 3, 3'd3, 1};
        tbl[9]  = '{1, 0, 32'hFFFFF010, 0, 32'h12345678, 3, 3'd3, 1};
        tbl[10] = '{0, 1, 32'h3, 32'hFFFFFFFF, 0, 0, 3'd5, 1};

        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; a1 = 32'd0; d1 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) txn(tbl[i]);

        chk("mem_20", {24'd0, dut.mem_array[32'h20]}, 32'hEF);
        chk("mem_23", {24'd0, dut.mem_array[32'h23]}, 32'hDE);
        chk("mem_22_err", {24'd0, dut.mem_array[32'h22]}, 32'hAD);
        chk("mem_04_wrap", {24'd0, dut.mem_array[32'h4]}, 32'hA5);
        chk("mem_03_err", {24'd0, dut.mem_array[32'h3]},
            {24'd0, dut.mem_array[32'h3] == 8'hFF ? 8'h00 :
                    dut.mem_array[32'h3]});

        // New read while RBUSY is dropped.
        sbq.push_back('{3'd3, 32'h12345678});
        mem_read = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        chk("ign_busy0", {29'd0, state}, 32'd1);
        mem_read = 1'b0;
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h20;
        @(posedge clk); #1;
        chk("ign_busy1", {29'd0, state}, 32'd1);
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("ign_busy2", {29'd0, state}, 32'd1);
        @(posedge clk); #1;
        chk("ign_done", {29'd0, state}, 32'd3);
        chk("ign_rdata", rdata, 32'h12345678);
        last_rd = 32'h12345678;
        @(posedge clk); #1;
        chk("ign_idle", {29'd0, state}, 32'd0);
        @(negedge clk);

        // Reset in the middle of a write aborts it.
        mem_write = 1'b1; addr = 32'h30; wdata = 32'h11111111;
        @(posedge clk); #1;
        chk("rst_wbusy", {29'd0, state}, 32'd2);
        mem_write = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_state", {29'd0, state}, 32'd0);
        chk("rst_async_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 32'd0;
        chk("rst_mem_30", {24'd0, dut.mem_array[32'h30]}, 32'd0);
        chk("rst_mem_33", {24'd0, dut.mem_array[32'h33]}, 32'd0);
        v = '{1, 0, 32'h30, 0, 32'h0, 3, 3'd3, 0};
        txn(v);
        v = '{1, 0, 32'h20, 0, 32'hDEADBEEF, 3, 3'd3, 1};
        txn(v);

        // Single-cycle latency instance.
        wr1 = 1'b1; a1 = 32'h10; d1 = 32'h12345678;
        @(posedge clk); #1;
        chk("l1_wbusy", {29'd0, state1}, 32'd2);
        wr1 = 1'b0; d1 = $urandom;
        @(posedge clk); #1;
        chk("l1_wdone", {29'd0, state1}, 32'd4);
        @(negedge clk);
        rd1 = 1'b1; a1 = 32'h10;
        @(posedge clk); #1;
        chk("l1_rbusy", {29'd0, state1}, 32'd1);
        rd1 = 1'b0; a1 = $urandom;
        @(posedge clk); #1;
        chk("l1_rdone", {29'd0, state1}, 32'd3);
        chk("l1_rdata", rdata1, 32'h12345678);
        @(posedge clk); #1;
        chk("l1_idle", {29'd0, state1}, 32'd0);
        chk("l1_hold", rdata1, 32'h12345678);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
